unary_frame_tx: RTL and testbench

Transmit side of the ones-count link in the router. The block accepts a count N through a valid/ready handshake and emits a serial frame of WIDTH bits: N ones followed by WIDTH−N zeros, LSB/bit 0 first. The matching ones-counter on the receive side recovers N by counting ones across the frame. The block also holds the frame as a parallel thermometer mask for local checking.

---
 rtl/unary_pkg.sv | 34 +++
 rtl/unary_frame_tx.sv | 150 +++++++++++++++
 tb/tb_unary_frame_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// -----------------------------------------------------------------------------
// unary_pkg
//   Shared definitions for the ones-count link transmit side.
//   - WIDTH_DEF / CW_DEF : default frame length and count-input width.
//   - MASK_MAX           : widest frame the thermometer helper can build.
//   - state_e            : transmitter FSM states.
//   - therm_mask()       : thermometer code, bit i set when i < n.
// -----------------------------------------------------------------------------
package unary_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CW_DEF    = 8;

    // The helper returns a fixed-width vector; callers slice off the low
    // WIDTH bits. Frames wider than this are not supported.
    localparam int MASK_MAX  = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Thermometer code of n: bit i = (i < n). Saturates naturally for
    // n >= MASK_MAX (all ones).
    function automatic logic [MASK_MAX-1:0] therm_mask(input int unsigned n);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/unary_frame_tx.sv
// -----------------------------------------------------------------------------
// unary_frame_tx
//   Transmit side of the ones-count link. Accepts a count N over a
//   valid/ready handshake and serialises a WIDTH-bit frame of N ones followed
//   by WIDTH-N zeros, bit 0 first. Counts above WIDTH saturate to WIDTH and
//   raise a one-cycle ovf pulse. The frame is also held as a parallel
//   thermometer mask for local checking.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_count   : requested number of ones (CW bits)
//   in_valid   : in_count is valid
//   in_ready   : block can accept a count this cycle
//   ser_bit    : current frame bit
//   ser_valid  : ser_bit is valid
//   ser_last   : current bit is frame bit WIDTH-1
//   ser_ready  : downstream accepts ser_bit
//   mask       : thermometer mask of the current / last frame
//   ovf        : one-cycle pulse when the accepted count exceeded WIDTH
// -----------------------------------------------------------------------------
module unary_frame_tx
    import unary_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    in_count,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic [WIDTH-1:0] mask,
    output logic             ovf
);

    // Bit index width, and the common width used for all count comparisons
    // so that in_count and idx compare as zero-extended unsigned values.
    localparam int IW   = $clog2(WIDTH);
    localparam int CMPW = (CW > IW + 1) ? CW : IW + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q,   idx_d;
    logic [CMPW-1:0]     n_q,     n_d;
    logic [WIDTH-1:0]    mask_q,  mask_d;
    logic                ovf_q,   ovf_d;

    // -------------------------------------------------------------------------
    // Incoming count: saturate to WIDTH and build its thermometer code
    // -------------------------------------------------------------------------
    logic [CMPW-1:0]     cnt_ext;
    logic                cnt_over;
    logic [CMPW-1:0]     n_new;
    logic [MASK_MAX-1:0] therm_full;

    always_comb begin
        cnt_ext  = CMPW'(in_count);
        cnt_over = (cnt_ext > CMPW'(WIDTH));
        n_new    = cnt_over ? CMPW'(WIDTH) : cnt_ext;
    end

    assign therm_full = therm_mask(32'(n_new));

    // Bits of the helper's result beyond the frame are always don't-care.
    generate
        if (WIDTH < MASK_MAX) begin : g_therm_hi
            logic unused_therm_hi;
            assign unused_therm_hi = ^therm_full[MASK_MAX-1:WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output decode (all driven from registered state, so reset values fall
    // out of state = IDLE)
    // -------------------------------------------------------------------------
    logic in_send;
    logic beat;
    logic accept;

    always_comb begin
        in_send   = (state_q == SEND);
        ser_valid = in_send;
        ser_bit   = in_send && (CMPW'(idx_q) < n_q);
        ser_last  = in_send && (idx_q == IW'(WIDTH - 1));
        // Ready on the last beat lets the next frame start with no bubble.
        in_ready  = (state_q == IDLE) || (ser_last && ser_ready);
        beat      = ser_valid && ser_ready;
        accept    = in_valid && in_ready;
    end

    assign mask = mask_q;
    assign ovf  = ovf_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        mask_d  = mask_q;
        ovf_d   = 1'b0;

        if (beat) begin
            if (ser_last) begin
                // idx is reloaded rather than allowed to wrap.
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end

        // An accept on the last beat overrides the return to IDLE above.
        if (accept) begin
            state_d = SEND;
            idx_d   = '0;
            n_d     = n_new;
            mask_d  = therm_full[WIDTH-1:0];
            ovf_d   = cnt_over;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_unary_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_unary_frame_tx
//   Directed self-checking bench for unary_frame_tx (WIDTH=32, CW=8).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_unary_frame_tx;
    import unary_pkg::*;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] in_count;
    logic          in_valid;
    logic          in_ready;
    logic          ser_bit;
    logic          ser_valid;
    logic          ser_last;
    logic          ser_ready;
    logic [W-1:0]  mask;
    logic          ovf;

    int errors = 0;
    int checks = 0;
    int ones;
    logic [MASK_MAX-1:0] tm;

    unary_frame_tx #(.WIDTH(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_ready (ser_ready),
        .mask      (mask),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consume one frame. Each sampled cycle checks bit, last, mask, ovf and
    // in_ready; with toggle set, ser_ready alternates 1,0,1,... and the bit
    // expected while stalled is the one for the not-yet-taken beat.
    task automatic recv_frame(input int n, input logic [W-1:0] emask, input bit eovf,
                              input bit toggle, output int cnt);
        int beat = 0;
        int cyc  = 0;
        cnt = 0;
        while (beat < W && cyc < 4 * W) begin
            if (toggle) ser_ready = (cyc % 2 == 0);
            @(negedge clk);
            chk("ser_valid", 64'(ser_valid), 64'(1));
            chk("ser_bit",   64'(ser_bit),   64'(beat < n));
            chk("ser_last",  64'(ser_last),  64'(beat == W - 1));
            chk("mask",      64'(mask),      64'(emask));
            chk("ovf",       64'(ovf),       64'((cyc == 0) ? eovf : 1'b0));
            chk("in_ready",  64'(in_ready),  64'((beat == W - 1) && ser_ready));
            if (ser_ready) begin
                cnt += int'(ser_bit);
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ser_ready = 1'b1;
        chk("beats", 64'(beat), 64'(W));
    endtask

    task automatic idle_check(input logic [W-1:0] emask);
        @(negedge clk);
        chk("idle_valid", 64'(ser_valid), 64'(0));
        chk("idle_bit",   64'(ser_bit),   64'(0));
        chk("idle_last",  64'(ser_last),  64'(0));
        chk("idle_ready", 64'(in_ready),  64'(1));
        chk("idle_mask",  64'(mask),      64'(emask));
        @(posedge clk); #1;
    endtask

    // Present a count while IDLE and let it be accepted on the next edge.
    task automatic offer(input int n);
        in_count = CW'(n);
        in_valid = 1'b1;
        @(negedge clk);
        chk("offer_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(ser_valid), 64'(0));
        chk("rst_bit",   64'(ser_bit),   64'(0));
        chk("rst_last",  64'(ser_last),  64'(0));
        chk("rst_mask",  64'(mask),      64'(0));
        chk("rst_ovf",   64'(ovf),       64'(0));
        chk("rst_ready", 64'(in_ready),  64'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // N = 5
        offer(5);
        in_valid = 1'b0;
        recv_frame(5, 32'h0000_001F, 1'b0, 1'b0, ones);
        chk("rx_5", 64'(ones), 64'(5));
        tm = therm_mask(5);
        @(negedge clk);
        chk("pkg_mask_5", 64'(mask), tm[63:0]);
        @(posedge clk); #1;
        idle_check(32'h0000_001F);

        // N = 0 then N = 32 back to back
        offer(0);
        in_count = 8'd32;
        recv_frame(0, 32'h0000_0000, 1'b0, 1'b0, ones);
        in_valid = 1'b0;
        chk("rx_0", 64'(ones), 64'(0));
        recv_frame(32, 32'hFFFF_FFFF, 1'b0, 1'b0, ones);
        chk("rx_32", 64'(ones), 64'(32));
        idle_check(32'hFFFF_FFFF);

        // N = 40 saturates
        offer(40);
        in_valid = 1'b0;
        recv_frame(32, 32'hFFFF_FFFF, 1'b1, 1'b0, ones);
        chk("rx_40", 64'(ones), 64'(32));
        idle_check(32'hFFFF_FFFF);

        // N = 12 with ser_ready toggling
        offer(12);
        in_valid = 1'b0;
        recv_frame(12, 32'h0000_0FFF, 1'b0, 1'b1, ones);
        chk("rx_12", 64'(ones), 64'(12));
        idle_check(32'h0000_0FFF);

        // Back-to-back 7, 20, 31
        offer(7);
        in_count = 8'd20;
        recv_frame(7, 32'h0000_007F, 1'b0, 1'b0, ones);
        chk("rx_7", 64'(ones), 64'(7));
        in_count = 8'd31;
        recv_frame(20, 32'h000F_FFFF, 1'b0, 1'b0, ones);
        chk("rx_20", 64'(ones), 64'(20));
        in_valid = 1'b0;
        recv_frame(31, 32'h7FFF_FFFF, 1'b0, 1'b0, ones);
        chk("rx_31", 64'(ones), 64'(31));
        idle_check(32'h7FFF_FFFF);

        // Reset on beat 10 of a 16-ones frame, with a count offered during rst
        offer(16);
        in_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            chk("pre_rst_bit", 64'(ser_bit), 64'(1));
            @(posedge clk); #1;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_count = 8'd9;
        @(negedge clk);
        chk("beat10_valid", 64'(ser_valid), 64'(1));
        chk("beat10_last",  64'(ser_last),  64'(0));
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(ser_valid), 64'(0));
        chk("abort_mask",  64'(mask),      64'(0));
        chk("abort_ready", 64'(in_ready),  64'(1));
        chk("abort_ovf",   64'(ovf),       64'(0));
        @(posedge clk); #1;
        offer(3);
        in_valid = 1'b0;
        recv_frame(3, 32'h0000_0007, 1'b0, 1'b0, ones);
        chk("rx_3", 64'(ones), 64'(3));
        idle_check(32'h0000_0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
